// File: rtl/credit_coalesce_rx.sv
// Credit-based receiver: per-VC fall-through FIFOs; freed slots are coalesced and returned as counted credits.
// Optional overflow detection is built only when CREDIT_RX_OVF_CHECK_EN is defined.
module credit_coalesce_rx #(
    parameter int VC_W         = 2,
    parameter int D_W          = 32,
    parameter int A_W          = 8,
    parameter int DEPTH        = 8,
    parameter int CREDIT_BATCH = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [VC_W-1:0]                               i_push_v,
    input  logic [A_W+D_W:0]                              i_push_d,
    output logic [VC_W-1:0]                               o_credit_v,
    output logic [VC_W-1:0][$clog2(DEPTH+1)-1:0]          o_credit_cnt,
    output logic [VC_W-1:0]                               o_v,
    output logic [VC_W-1:0][A_W+D_W:0]                    o_d,
    input  logic [VC_W-1:0]                               i_b,
    output logic                                          o_err
);
    localparam int FW    = A_W + D_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(FLUSH_CYCLES + 1);

    logic [FW-1:0]                mem_r [VC_W][DEPTH];
    logic [VC_W-1:0][PTR_W-1:0]   wr_ptr_r;
    logic [VC_W-1:0][PTR_W-1:0]   rd_ptr_r;
    logic [VC_W-1:0][CNT_W-1:0]   count_r;
    logic [VC_W-1:0]              v_r;
    logic [VC_W-1:0][CNT_W-1:0]   acc_r;
    logic [VC_W-1:0][TMR_W-1:0]   tmr_r;
    logic [VC_W-1:0]              credit_v_r;
    logic [VC_W-1:0][CNT_W-1:0]   credit_cnt_r;

    logic [VC_W-1:0]              full_s;
    logic [VC_W-1:0]              pop_s;
    logic [VC_W-1:0]              push_ok_s;
    logic [VC_W-1:0]              flush_s;
    logic [VC_W-1:0][CNT_W-1:0]   count_nxt_s;
    logic [VC_W-1:0][CNT_W-1:0]   acc_sum_s;

    // Per-VC occupancy, pop/push qualification and credit-return decision.
    always_comb begin
        full_s      = {VC_W{1'b0}};
        pop_s       = {VC_W{1'b0}};
        push_ok_s   = {VC_W{1'b0}};
        flush_s     = {VC_W{1'b0}};
        count_nxt_s = {(VC_W*CNT_W){1'b0}};
        acc_sum_s   = {(VC_W*CNT_W){1'b0}};
        for (int i = 0; i < VC_W; i++) begin
            full_s[i]      = (count_r[i] == CNT_W'(DEPTH));
            pop_s[i]       = v_r[i] & ~i_b[i];
            push_ok_s[i]   = i_push_v[i] & ~full_s[i];
            count_nxt_s[i] = count_r[i] + CNT_W'(push_ok_s[i]) - CNT_W'(pop_s[i]);
            acc_sum_s[i]   = acc_r[i] + CNT_W'(pop_s[i]);
            // A partial batch is flushed on the last cycle of its hold window.
            if (acc_sum_s[i] >= CNT_W'(CREDIT_BATCH)) begin
                flush_s[i] = 1'b1;
            end else if ((acc_sum_s[i] != {CNT_W{1'b0}}) && (tmr_r[i] == TMR_W'(FLUSH_CYCLES - 1))) begin
                flush_s[i] = 1'b1;
            end else begin
                flush_s[i] = 1'b0;
            end
        end
    end

    // FIFO storage; payload words need no reset since o_v qualifies them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VC_W; i++) begin
            if (push_ok_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= i_push_d;
            end
        end
    end

    // FIFO pointers, occupancy and registered head-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(VC_W*PTR_W){1'b0}};
            rd_ptr_r <= {(VC_W*PTR_W){1'b0}};
            count_r  <= {(VC_W*CNT_W){1'b0}};
            v_r      <= {VC_W{1'b0}};
        end else begin
            for (int i = 0; i < VC_W; i++) begin
                if (push_ok_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                count_r[i] <= count_nxt_s[i];
                v_r[i]     <= (count_nxt_s[i] != {CNT_W{1'b0}});
            end
        end
    end

    // Credit coalescer: accumulator, hold timer and registered credit return.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= {(VC_W*CNT_W){1'b0}};
            tmr_r        <= {(VC_W*TMR_W){1'b0}};
            credit_v_r   <= {VC_W{1'b0}};
            credit_cnt_r <= {(VC_W*CNT_W){1'b0}};
        end else begin
            for (int i = 0; i < VC_W; i++) begin
                if (flush_s[i]) begin
                    credit_v_r[i]   <= 1'b1;
                    credit_cnt_r[i] <= acc_sum_s[i];
                    acc_r[i]        <= {CNT_W{1'b0}};
                    tmr_r[i]        <= {TMR_W{1'b0}};
                end else begin
                    credit_v_r[i]   <= 1'b0;
                    credit_cnt_r[i] <= {CNT_W{1'b0}};
                    acc_r[i]        <= acc_sum_s[i];
                    tmr_r[i]        <= (acc_sum_s[i] != {CNT_W{1'b0}}) ? (tmr_r[i] + TMR_W'(1)) : {TMR_W{1'b0}};
                end
            end
        end
    end

    // Head flit of each VC read straight from storage (fall-through).
    always_comb begin
        o_d = {(VC_W*FW){1'b0}};
        for (int i = 0; i < VC_W; i++) begin
            o_d[i] = mem_r[i][rd_ptr_r[i]];
        end
    end

    assign o_v          = v_r;
    assign o_credit_v   = credit_v_r;
    assign o_credit_cnt = credit_cnt_r;

`ifdef CREDIT_RX_OVF_CHECK_EN
    logic err_r;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | (|(i_push_v & full_s));
        end
    end

    assign o_err = err_r;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_coalesce_rx.sv
// Bench for credit_coalesce_rx: two instances (batch 4 and batch 1) share stimulus and are checked
// every cycle against a queue/timestamp model, plus literal pulse-timing expectations.
module tb_credit_coalesce_rx;
    localparam int VC_W = 2;
    localparam int FW = 41;
    localparam int DEPTH = 8;
    localparam int FLUSH = 16;
    localparam int CNT_W = 4;

    typedef logic [FW-1:0] flit_t;
    typedef struct {int c; int k; int vc; int n;} ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                   rst;
    logic [VC_W-1:0]                        push_v;
    logic [VC_W-1:0]                        ib;
    flit_t                                  push_d;
    logic [1:0][VC_W-1:0]                   cv;
    logic [1:0][VC_W-1:0]                   dv;
    logic [1:0][VC_W-1:0][CNT_W-1:0]        cc;
    logic [1:0][VC_W-1:0][FW-1:0]           dd;
    logic [1:0]                             derr;

    credit_coalesce_rx #(.VC_W(2), .D_W(32), .A_W(8), .DEPTH(8), .CREDIT_BATCH(4), .FLUSH_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .i_push_v(push_v), .i_push_d(push_d),
        .o_credit_v(cv[0]), .o_credit_cnt(cc[0]), .o_v(dv[0]), .o_d(dd[0]),
        .i_b(ib), .o_err(derr[0]));

    credit_coalesce_rx #(.VC_W(2), .D_W(32), .A_W(8), .DEPTH(8), .CREDIT_BATCH(1), .FLUSH_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .i_push_v(push_v), .i_push_d(push_d),
        .o_credit_v(cv[1]), .o_credit_cnt(cc[1]), .o_v(dv[1]), .o_d(dd[1]),
        .i_b(ib), .o_err(derr[1]));

    // Reference model: FIFOs as queues, coalescing as pending count + timestamp of first freed slot.
    flit_t q [2][$];
    int    pend  [2][2];
    int    first [2][2];
    bit    ecv   [2][2];
    int    ecnt  [2][2];
    bit    eerr;
    int    mpops [2];
    int    dsum  [2][2];
    int    cyc = 0;
    ev_t   lg [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic int batch_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic flit_t mkflit(input int j, input int tag);
        flit_t f;
        f = {(j == 8) ? 1'b1 : 1'b0, 8'(j), 32'(tag * 256 + j)};
        return f;
    endfunction

    task automatic model_step();
        bit pop [2];
        bit full [2];
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                q[i].delete();
                for (int k = 0; k < 2; k++) begin
                    pend[k][i] = 0; ecv[k][i] = 1'b0; ecnt[k][i] = 0;
                end
            end
            eerr = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                full[i] = (q[i].size() == DEPTH);
                pop[i]  = (q[i].size() != 0) && !ib[i];
            end
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) begin
                    void'(q[i].pop_front());
                    mpops[i]++;
                end
                if (push_v[i]) begin
                    if (full[i]) begin
`ifdef CREDIT_RX_OVF_CHECK_EN
                        eerr = 1'b1;
`endif
                    end else begin
                        q[i].push_back(push_d);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 2; i++) begin
                    if (pop[i]) begin
                        if (pend[k][i] == 0) first[k][i] = cyc;
                        pend[k][i]++;
                    end
                    if (pend[k][i] >= batch_of(k) || (pend[k][i] != 0 && cyc - first[k][i] == FLUSH - 1)) begin
                        ecv[k][i] = 1'b1; ecnt[k][i] = pend[k][i]; pend[k][i] = 0;
                    end else begin
                        ecv[k][i] = 1'b0; ecnt[k][i] = 0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("i%0d vc%0d o_v", k, i), 64'(dv[k][i]), 64'(q[i].size() != 0));
                if (q[i].size() != 0) check($sformatf("i%0d vc%0d o_d", k, i), 64'(dd[k][i]), 64'(q[i][0]));
                check($sformatf("i%0d vc%0d credit_v", k, i), 64'(cv[k][i]), 64'(ecv[k][i]));
                check($sformatf("i%0d vc%0d credit_cnt", k, i), 64'(cc[k][i]), 64'(ecnt[k][i]));
                if (cv[k][i] === 1'b1) begin
                    lg.push_back('{c: cyc, k: k, vc: i, n: int'(cc[k][i])});
                    dsum[k][i] += int'(cc[k][i]);
                end
            end
            check($sformatf("i%0d o_err", k), 64'(derr[k]), 64'(eerr));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        compare();
    end

    task automatic check_pulses(input string nm, input int k, input int vc, input int n,
                                input int c0, input int n0, input int c1, input int n1,
                                input int c2, input int n2);
        int cs[$];
        int ns[$];
        int ec;
        int en;
        foreach (lg[j]) begin
            if (lg[j].k == k && lg[j].vc == vc) begin
                cs.push_back(lg[j].c);
                ns.push_back(lg[j].n);
            end
        end
        check({nm, " pulse count"}, 64'(cs.size()), 64'(n));
        for (int j = 0; j < n && j < cs.size(); j++) begin
            ec = (j == 0) ? c0 : (j == 1) ? c1 : c2;
            en = (j == 0) ? n0 : (j == 1) ? n1 : n2;
            check($sformatf("%s pulse%0d cycle", nm, j), 64'(cs[j]), 64'(ec));
            check($sformatf("%s pulse%0d cnt", nm, j), 64'(ns[j]), 64'(en));
        end
    endtask

    task automatic drive(input logic [1:0] pv, input flit_t pd, input logic [1:0] b);
        @(negedge clk);
        push_v = pv;
        push_d = pd;
        ib     = b;
    endtask

    int base;
    int d;
    flit_t head0;
    logic [1:0] pv;

    initial begin
        rst = 1'b1; push_v = 2'b00; push_d = '0; ib = 2'b00;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset i%0d o_v", k), 64'(dv[k]), 64'd0);
            check($sformatf("reset i%0d credit_v", k), 64'(cv[k]), 64'd0);
            check($sformatf("reset i%0d credit_cnt", k), 64'(cc[k]), 64'd0);
            check($sformatf("reset i%0d o_err", k), 64'(derr[k]), 64'd0);
        end
        rst = 1'b0;

        // Three flits to VC0, no backpressure: single flush of 3 at +17.
        lg.delete();
        for (int j = 0; j < 3; j++) begin
            drive(2'b01, mkflit(j, 1), 2'b00);
            if (j == 0) base = cyc;
        end
        repeat (22) drive(2'b00, '0, 2'b00);
        check_pulses("t1 b4 vc0", 0, 0, 1, base + 17, 3, 0, 0, 0, 0);
        check_pulses("t1 b4 vc1", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_pulses("t1 b1 vc0", 1, 0, 3, base + 2, 1, base + 3, 1, base + 4, 1);

        // Eight flits to blocked VC1, then release: two batches of 4.
        lg.delete();
        for (int j = 0; j < 8; j++) drive(2'b10, mkflit(j, 2), 2'b10);
        repeat (4) drive(2'b00, '0, 2'b10);
        check("t2 o_v[1] held", 64'(dv[0][1]), 64'd1);
        drive(2'b00, '0, 2'b00);
        d = cyc;
        repeat (20) drive(2'b00, '0, 2'b00);
        check_pulses("t2 b4 vc1", 0, 1, 2, d + 4, 4, d + 8, 4, 0, 0);
        check_pulses("t2 b4 vc0", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Batch of one: pops at +5, +6, +9 give pulses at +6, +7, +10.
        lg.delete();
        for (int j = 0; j < 3; j++) begin
            drive(2'b01, mkflit(j, 3), 2'b01);
            if (j == 0) base = cyc;
        end
        for (int j = 3; j <= 24; j++) drive(2'b00, '0, (j == 5 || j == 6 || j == 9) ? 2'b00 : 2'b01);
        check_pulses("t3 b1 vc0", 1, 0, 3, base + 6, 1, base + 7, 1, base + 10, 1);
        check_pulses("t3 b4 vc0", 0, 0, 1, base + 21, 3, 0, 0, 0, 0);

        // Mid-operation reset with 5 queued and 2 credits pending.
        for (int j = 0; j < 5; j++) drive(2'b01, mkflit(j, 4), 2'b01);
        repeat (2) drive(2'b00, '0, 2'b00);
        drive(2'b00, '0, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst i%0d o_v", k), 64'(dv[k]), 64'd0);
            check($sformatf("midrst i%0d credit_v", k), 64'(cv[k]), 64'd0);
        end
        lg.delete();
        drive(2'b01, mkflit(0, 5), 2'b00);
        base = cyc;
        repeat (22) drive(2'b00, '0, 2'b00);
        check_pulses("t4 b4 vc0", 0, 0, 1, base + 17, 1, 0, 0, 0, 0);
        check_pulses("t4 b1 vc0", 1, 0, 1, base + 2, 1, 0, 0, 0, 0);

        // Random interleaved traffic with random backpressure; conservation checked after drain.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mpops[i] = 0;
            dsum[0][i] = 0;
            dsum[1][i] = 0;
        end
        for (int n = 0; n < 1000; n++) begin
            pv = 2'($urandom_range(0, 3));
            if (q[0].size() >= DEPTH) pv[0] = 1'b0;
            if (q[1].size() >= DEPTH) pv[1] = 1'b0;
            drive(pv, {9'($urandom), 32'($urandom)}, 2'($urandom_range(0, 3)));
        end
        repeat (40) drive(2'b00, '0, 2'b00);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rand i%0d vc%0d credits==pops", k, i), 64'(dsum[k][i]), 64'(mpops[i]));
            end
        end

        // Overflow: ninth push to blocked VC0 is dropped.
        for (int j = 0; j < 9; j++) drive(2'b01, mkflit(j, 6), 2'b01);
        head0 = mkflit(0, 6);
        drive(2'b00, '0, 2'b01);
`ifdef CREDIT_RX_OVF_CHECK_EN
        check("ovf o_err", 64'(derr[0]), 64'd1);
`else
        check("ovf o_err", 64'(derr[0]), 64'd0);
`endif
        check("ovf head unchanged", 64'(dd[0][0]), 64'(head0));
        repeat (3) drive(2'b00, '0, 2'b01);
`ifdef CREDIT_RX_OVF_CHECK_EN
        check("ovf o_err sticky", 64'(derr[0]), 64'd1);
`else
        check("ovf o_err sticky", 64'(derr[0]), 64'd0);
`endif
        repeat (30) drive(2'b00, '0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("final o_err cleared", 64'(derr[0]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/credit_coalesce_rx.md
Name: credit_coalesce_rx

Overview:
Next-generation credit-based backpressure receiver for the t/pi switch router. Each VC has a FIFO of arbitrary power-of-two depth, and the DVR interface to the routing logic is kept. Instead of returning one credit per pop, freed slots are coalesced per VC and returned as a counted credit, either when a batch threshold is reached or when a flush timeout expires. The block sits between the link-level transmitter (credit tx side) and the switch routing logic.

Parameters:
VC_W, 2, number of virtual channels
D_W, 32, payload data width
A_W, 8, address width
DEPTH, 8, per-VC FIFO entries; power of two, >=2; the transmitter holds DEPTH credits per VC
CREDIT_BATCH, 4, freed slots that trigger an immediate credit return; 1..DEPTH
FLUSH_CYCLES, 16, maximum cycles a nonzero partial batch is held; >=1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_push_v  in  VC_W  per-VC push strobe; one-hot or zero
i_push_d  in  A_W+D_W+1  {last, addr, data} for the pushed flit
o_credit_v  out  VC_W  per-VC credit-return strobe
o_credit_cnt  out  VC_W x CNT_W  credits returned, valid with o_credit_v; CNT_W=$clog2(DEPTH+1)
o_v  out  VC_W  per-VC head valid
o_d  out  VC_W x (A_W+D_W+1)  per-VC head flit
i_b  in  VC_W  per-VC backpressure, active-high
o_err  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high on rst.
- Reset values:
  - All FIFOs empty; o_v=0; o_credit_v=0; o_credit_cnt=0; o_err=0.
  - Accumulators and timers cleared.
  - Credits held in accumulators at reset are discarded; the transmitter shares rst and reinitialises to DEPTH credits.
- FIFO, per VC, fall-through head:
  - Push at cycle t is visible at o_v/o_d at t+1.
  - No same-cycle bypass when empty.
  - Ordering is preserved per VC.
- pop[i] = o_v[i] & !i_b[i]. The head advances the next cycle.
- A simultaneous push and pop on the same VC is legal; occupancy is unchanged.
- Full FIFO: a push is dropped and contents are unchanged. This cannot happen with a correct transmitter.
- Multi-hot i_push_v is illegal. If it occurs, each set bit pushes i_push_d.
- o_v[i] never falls while i_b[i]=1. o_d[i] is stable while o_v[i]=1 and i_b[i]=1.
- Credit coalescer, per VC, with registers acc (CNT_W) and tmr ($clog2(FLUSH_CYCLES+1)):
  - a = acc + pop.
  - If a >= CREDIT_BATCH, or (a != 0 and tmr == FLUSH_CYCLES-1): next cycle o_credit_v=1 and o_credit_cnt=a; set acc<=0, tmr<=0.
  - Otherwise: o_credit_v<=0; acc<=a; tmr <= (a!=0) ? tmr+1 : 0.
  - Credit outputs are registered: a return is visible 1 cycle after the triggering pop cycle.
  - o_credit_cnt is 0 when o_credit_v=0.
  - acc never exceeds DEPTH, so no overflow occurs.
  - Total credits returned equals total pops. No credit is lost or duplicated outside reset.
- VCs are fully independent. Coalescers do not share state or timers.

Optional Feature:
- Macro CREDIT_RX_OVF_CHECK_EN.
- Defined: a push to a full VC sets o_err=1. o_err stays 1 until rst.
- Undefined: o_err is tied to 0 and no detection logic is built.
- A push to a full VC is dropped in both modes.

Test Plan:
- Reset, then push 3 flits to VC0 at cycles 0-2 with i_b=0:
  - o_v[0]=1 at cycles 1-3 with data in order.
  - Exactly one o_credit_v[0] pulse, cnt=3, at cycle 17.
  - No other credit pulses.
- i_b[1]=1, push 8 flits to VC1:
  - o_v[1] held 1; no credits.
  - Drop i_b[1]: 8 pops, then two pulses of cnt=4, each 1 cycle after the 4th and 8th pop.
- Interleaved pushes to VC0/VC1 with random i_b for 1000 cycles:
  - Per-VC order is preserved.
  - Sum of o_credit_cnt per VC equals pops; occupancy never exceeds 8.
- CREDIT_BATCH=1: pops at cycles 5, 6 and 9 give cnt=1 pulses at cycles 6, 7 and 10.
- Mid-operation reset, with 5 flits queued on VC0 and acc=2, rst high for 1 cycle:
  - Next cycle o_v=0, o_credit_v=0.
  - A push afterwards behaves as from cold reset.
- With CREDIT_RX_OVF_CHECK_EN, a 9th push to VC0 with i_b[0]=1:
  - o_err=1 next cycle and stays 1; the head flit is unchanged.
  - Without the macro, o_err=0.
